// File: rtl/debounce.sv
// Switch debouncer: two-flop synchronizer feeding a four-state stability timer.
// Define DEBOUNCE_TOGGLE_EN to make o_led toggle on each accepted press instead of following the level.
module debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sw,
   output logic o_led,
   output logic o_press,
   output logic o_release,
   output logic o_busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   // The sample that moves the FSM into a timing state is the first stable cycle,
   // so the timing state only needs DEBOUNCE_CYCLES-1 further confirming samples.
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      S_LOW,
      S_RISING,
      S_HIGH,
      S_FALLING
   } state_t;

   state_t state;
   state_t state_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic sync_meta;
   logic sync;
   logic press_next;
   logic release_next;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= i_sw;
         sync      <= sync_meta;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_LOW;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next   = state;
      count_next   = count;
      press_next   = 1'b0;
      release_next = 1'b0;
      case (state)
         S_LOW: begin
            if (sync) begin
               state_next = S_RISING;
               count_next = '0;
            end
         end
         S_RISING: begin
            if (!sync) begin
               state_next = S_LOW;
               count_next = '0;
            end else if (count == LAST) begin
               state_next = S_HIGH;
               count_next = '0;
               press_next = 1'b1;
            end else begin
               count_next = count + 1'b1;
            end
         end
         S_HIGH: begin
            if (!sync) begin
               state_next = S_FALLING;
               count_next = '0;
            end
         end
         S_FALLING: begin
            if (sync) begin
               state_next = S_HIGH;
               count_next = '0;
            end else if (count == LAST) begin
               state_next   = S_LOW;
               count_next   = '0;
               release_next = 1'b1;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: begin
            state_next = S_LOW;
            count_next = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_led     <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         o_press   <= press_next;
         o_release <= release_next;
         o_busy    <= (state_next == S_RISING) || (state_next == S_FALLING);
`ifdef DEBOUNCE_TOGGLE_EN
         if (press_next) begin
            o_led <= ~o_led;
         end
`else
         o_led     <= (state_next == S_HIGH) || (state_next == S_FALLING);
`endif
      end
   end

endmodule

// File: tb/tb_debounce.sv
// Scoreboard bench for debounce: a run-length reference model predicts every cycle's outputs,
// and directed scenarios pin down press/release timing, bounce, glitch, reset and toggle behaviour.
module tb_debounce;

   localparam int N = 4;
`ifdef DEBOUNCE_TOGGLE_EN
   localparam bit TOG = 1'b1;
`else
   localparam bit TOG = 1'b0;
`endif

   typedef struct packed {
      logic led;
      logic press;
      logic rel;
      logic busy;
   } exp_t;

   logic i_clk;
   logic i_reset;
   logic i_sw;
   logic o_led;
   logic o_press;
   logic o_release;
   logic o_busy;

   int checks;
   int failures;
   int sbChecks;
   int pressCount;
   int pressBefore;
   int len;
   logic lvl;

   exp_t expQ[$];
   exp_t got;
   exp_t want;

   bit hist[$];
   bit acc;
   bit mLed;
   int run;
   bit smp;

   debounce #(.DEBOUNCE_CYCLES(N)) dut (
      .i_clk(i_clk),
      .i_reset(i_reset),
      .i_sw(i_sw),
      .o_led(o_led),
      .o_press(o_press),
      .o_release(o_release),
      .o_busy(o_busy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Reference model: the level flips once N consecutive synchronized samples disagree with it.
   always @(posedge i_clk) begin
      exp_t e;
      e = '0;
      if (i_reset) begin
         hist = {1'b0, 1'b0};
         acc  = 1'b0;
         mLed = 1'b0;
         run  = 0;
      end else begin
         if (hist.size() < 2) hist = {1'b0, 1'b0};
         smp = hist.pop_front();
         hist.push_back(i_sw);
         if (smp != acc) begin
            run = run + 1;
            if (run == N) begin
               acc = smp;
               run = 0;
               if (smp) begin
                  e.press = 1'b1;
                  mLed = ~mLed;
               end else begin
                  e.rel = 1'b1;
               end
            end
         end else begin
            run = 0;
         end
         e.busy = (run != 0);
         e.led  = TOG ? mLed : acc;
      end
      expQ.push_back(e);
   end

   always @(negedge i_clk) begin
      if (expQ.size() > 0) begin
         want = expQ.pop_front();
         got  = {o_led, o_press, o_release, o_busy};
         checks++;
         sbChecks++;
         if (got !== want) begin
            failures++;
            $display("[TB] FAIL scoreboard t=%0t: got led/press/rel/busy=%b expected %b", $time, got, want);
         end
         checks++;
         if (o_press === 1'b1 && o_release === 1'b1) begin
            failures++;
            $display("[TB] FAIL press_and_release t=%0t: got both high, expected at most one", $time);
         end
      end
      if (o_press === 1'b1) pressCount++;
   end

   task automatic applyStimulus(input logic sw, input logic rst);
      @(negedge i_clk);
      i_sw    = sw;
      i_reset = rst;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] expv);
      logic [3:0] act;
      #1;
      act = {o_led, o_press, o_release, o_busy};
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s: got led/press/rel/busy=%b expected %b", name, act, expv);
      end
   endtask

   task automatic checkCount(input string name, input int act, input int expv);
      #1;
      checks++;
      if (act != expv) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
   endtask

   task automatic pressCycle(input logic ledAfterPress, input logic ledAfterRelease);
      applyStimulus(1'b1, 1'b0);
      repeat (6) applyStimulus(1'b1, 1'b0);
      checkOutput("toggle_press", {ledAfterPress, 1'b1, 1'b0, 1'b0});
      repeat (4) applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      repeat (6) applyStimulus(1'b0, 1'b0);
      checkOutput("toggle_release", {ledAfterRelease, 1'b0, 1'b1, 1'b0});
      repeat (4) applyStimulus(1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] bounce;
      checks     = 0;
      failures   = 0;
      sbChecks   = 0;
      pressCount = 0;
      i_sw       = 1'b0;
      i_reset    = 1'b1;
      bounce     = 8'b1111_1011;

      doReset();
      checkOutput("reset_state", 4'b0000);

      // Clean press from reset release: busy after edges 3-5, press and led at edge 6.
      applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0);
      checkOutput("press_edge2_idle", 4'b0000);
      repeat (3) applyStimulus(1'b1, 1'b0);
      checkOutput("press_edge5_busy", 4'b0001);
      applyStimulus(1'b1, 1'b0);
      checkOutput("press_edge6_pulse", 4'b1100);
      applyStimulus(1'b1, 1'b0);
      checkOutput("press_edge7_hold", 4'b1000);
      repeat (13) applyStimulus(1'b1, 1'b0);

      // Release from accepted high.
      applyStimulus(1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0);
      checkOutput("release_edge5_busy", {1'b1, 1'b0, 1'b0, 1'b1});
      applyStimulus(1'b0, 1'b0);
      checkOutput("release_edge6_pulse", {TOG, 1'b0, 1'b1, 1'b0});
      repeat (8) applyStimulus(1'b0, 1'b0);

      // Bounce: exactly one press once four synchronized ones are seen.
      doReset();
      pressBefore = pressCount;
      for (int i = 0; i < 8; i++) applyStimulus(bounce[i], 1'b0);
      repeat (10) applyStimulus(1'b1, 1'b0);
      checkCount("bounce_press_count", pressCount - pressBefore, 1);
      checkOutput("bounce_settled", 4'b1000);

      // Glitch of three cycles: nothing but busy.
      doReset();
      pressBefore = pressCount;
      repeat (3) applyStimulus(1'b1, 1'b0);
      repeat (10) applyStimulus(1'b0, 1'b0);
      checkCount("glitch_press_count", pressCount - pressBefore, 0);
      checkOutput("glitch_quiet", 4'b0000);

      // Reset while timing a rising candidate.
      doReset();
      pressBefore = pressCount;
      repeat (4) applyStimulus(1'b1, 1'b0);
      checkOutput("midtiming_busy", 4'b0001);
      applyStimulus(1'b1, 1'b1);
      applyStimulus(1'b1, 1'b0);
      checkOutput("midtiming_reset", 4'b0000);
      checkCount("midtiming_press_count", pressCount - pressBefore, 0);
      repeat (12) applyStimulus(1'b0, 1'b0);

      // Two full press/release cycles.
      doReset();
      pressCycle(1'b1, TOG);
      pressCycle(TOG ? 1'b0 : 1'b1, 1'b0);

      // Randomized bursts with occasional resets, checked by the scoreboard.
      for (int b = 0; b < 80; b++) begin
         if ($urandom_range(0, 15) == 0) begin
            applyStimulus(1'b0, 1'b1);
         end else begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            repeat (len) applyStimulus(lvl, 1'b0);
         end
      end
      repeat (10) applyStimulus(1'b0, 1'b0);

      repeat (2) @(negedge i_clk);
      #1;
      checkCount("scoreboard_drained", expQ.size(), 0);
      checks++;
      if (sbChecks < 200) begin
         failures++;
         $display("[TB] FAIL scoreboard_activity: got %0d expected at least 200", sbChecks);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
